// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC core and its fixed-to-float back end.
package cordic_pkg;

  localparam int unsigned CORDIC_W = 32;
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;
  localparam int unsigned FP_BIAS  = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } f2f_state_t;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-one position encoder for a 32-bit word.
module lzc32 (
  input  logic [31:0] v,
  output logic [4:0]  p,
  output logic        zero
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) p = 5'(i);
    end
    zero = ~|v;
  end

endmodule

// File: rtl/cordic_fix2float.sv
// Multi-cycle signed fixed-point to IEEE-754 single converter with
// clk_en/start/done handshake.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 31
) (
  input  logic                clock,
  input  logic                aclr_n,
  input  logic                clk_en,
  input  logic                start,
  input  logic [CORDIC_W-1:0] dataa,
  output logic                busy,
  output logic                done,
  output logic [31:0]         result
);

  f2f_state_t          state_q, state_d;
  logic [CORDIC_W-1:0] data_q, data_d;
  logic [CORDIC_W-1:0] norm_q, norm_d;
  logic [FP_EXP_W-1:0] exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [31:0]         result_q, result_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [CORDIC_W-1:0] mag;
  logic [4:0]          lead_p;
  logic                lead_zero;

  assign mag = data_q[CORDIC_W-1] ? (~data_q + 32'd1) : data_q;

  lzc32 u_lzc (
    .v    (mag),
    .p    (lead_p),
    .zero (lead_zero)
  );

  // Rounding fields from the normalized magnitude (bit 31 is the hidden one).
  logic [FP_MAN_W-1:0] man_raw;
  logic                guard_b, sticky_b, round_up;
  logic [FP_MAN_W:0]   man_rnd;

  always_comb begin
    man_raw  = norm_q[30:8];
    guard_b  = norm_q[7];
    sticky_b = |norm_q[6:0];
    round_up = guard_b & (sticky_b | man_raw[0]);
    man_rnd  = {1'b0, man_raw} + (FP_MAN_W + 1)'(round_up);
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    norm_d   = norm_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = dataa;
          state_d = NORM;
        end
      end
      NORM: begin
        sign_d = data_q[CORDIC_W-1];
        if (lead_zero) begin
          norm_d = '0;
          exp_d  = '0;
        end else begin
          norm_d = mag << (5'd31 - lead_p);
          exp_d  = FP_EXP_W'(FP_BIAS + 32'(lead_p) - FRAC_BITS);
        end
        state_d = ROUND;
      end
      ROUND: begin
        // A clear hidden bit means the operand was zero.
        if (!norm_q[31]) begin
          result_d = 32'h0000_0000;
        end else if (man_rnd[FP_MAN_W]) begin
          result_d = {sign_q, exp_q + 8'd1, {FP_MAN_W{1'b0}}};
        end else begin
          result_d = {sign_q, exp_q, man_rnd[FP_MAN_W-1:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          data_d  = dataa;
          state_d = NORM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == NORM) || (state_d == ROUND);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      norm_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      data_q   <= data_d;
      norm_q   <= norm_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Directed bench for cordic_fix2float: vector table on two FRAC_BITS
// instances plus handshake corner sequences.
module tb_cordic_fix2float;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;

  logic        busy31, done31, busy0, done0;
  logic [31:0] result31, result0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cordic_fix2float #(.FRAC_BITS(31)) u_dut31 (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .busy   (busy31),
    .done   (done31),
    .result (result31)
  );

  cordic_fix2float #(.FRAC_BITS(0)) u_dut0 (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .busy   (busy0),
    .done   (done0),
    .result (result0)
  );

  typedef struct {
    bit          frac0;
    logic [31:0] din;
    logic [31:0] exp_res;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
    end
  endtask

  function automatic logic sel_done(input bit frac0);
    return frac0 ? done0 : done31;
  endfunction

  function automatic logic [31:0] sel_result(input bit frac0);
    return frac0 ? result0 : result31;
  endfunction

  // Single start pulse; returns number of enabled edges until done is seen.
  task automatic convert(input bit frac0, input logic [31:0] din, output int edges);
    int n;
    @(negedge clock);
    start = 1'b1;
    dataa = din;
    n = 0;
    edges = -1;
    while (n < 10) begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (sel_done(frac0)) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    logic [31:0] held;
    logic saw_done;

    vecs.push_back('{1'b0, 32'h4000_0000, 32'h3F00_0000, "half"});
    vecs.push_back('{1'b0, 32'h4DBA_76D4, 32'h3F1B_74EE, "gain_roundup"});
    vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h3F80_0000, "carry_out"});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hBF80_0000, "neg_one"});
    vecs.push_back('{1'b0, 32'hC000_0000, 32'hBF00_0000, "neg_half"});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, "zero"});
    vecs.push_back('{1'b1, 32'h0100_0001, 32'h4B80_0000, "tie_even_down"});
    vecs.push_back('{1'b1, 32'h0100_0003, 32'h4B80_0002, "tie_even_up"});
    vecs.push_back('{1'b1, 32'h0000_0001, 32'h3F80_0000, "int_one"});

    aclr_n = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    repeat (3) @(negedge clock);
    check("reset_result", result31, 32'h0);
    check("reset_done", {31'd0, done31}, 32'd0);
    check("reset_busy", {31'd0, busy31}, 32'd0);
    aclr_n = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      convert(vecs[i].frac0, vecs[i].din, edges);
      check({vecs[i].name, "_latency"}, 32'(edges - 1), 32'd2);
      check(vecs[i].name, sel_result(vecs[i].frac0), vecs[i].exp_res);
      @(negedge clock);
      check({vecs[i].name, "_done_fall"}, {31'd0, sel_done(vecs[i].frac0)}, 32'd0);
    end

    // Freeze five cycles while in ROUND.
    @(negedge clock);
    held = result31;
    start = 1'b1;
    dataa = 32'h4000_0000;
    @(negedge clock);
    start = 1'b0;
    check("freeze_busy_norm", {31'd0, busy31}, 32'd1);
    @(negedge clock);
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("freeze_no_done", {31'd0, done31}, 32'd0);
      check("freeze_result_held", result31, held);
    end
    clk_en = 1'b1;
    @(negedge clock);
    check("freeze_done", {31'd0, done31}, 32'd1);
    check("freeze_result", result31, 32'h3F00_0000);
    clk_en = 1'b0;
    repeat (2) @(negedge clock);
    check("freeze_done_held", {31'd0, done31}, 32'd1);
    clk_en = 1'b1;
    @(negedge clock);
    check("freeze_done_fall", {31'd0, done31}, 32'd0);

    // Asynchronous reset in NORM discards the conversion.
    start = 1'b1;
    dataa = 32'h7FFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    check("aclr_busy_before", {31'd0, busy31}, 32'd1);
    aclr_n = 1'b0;
    #1;
    check("aclr_busy", {31'd0, busy31}, 32'd0);
    check("aclr_done", {31'd0, done31}, 32'd0);
    check("aclr_result", result31, 32'h0);
    @(negedge clock);
    aclr_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (done31) saw_done = 1'b1;
    end
    check("aclr_no_done", {31'd0, saw_done}, 32'd0);

    // start held: one result every third enabled cycle.
    start = 1'b1;
    dataa = 32'h4000_0000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      check($sformatf("b2b_done_%0d", k), {31'd0, done31}, {31'd0, (k % 3 == 0)});
      if (k == 3) begin
        check("b2b_result_a", result31, 32'h3F00_0000);
        dataa = 32'hC000_0000;
      end
      if (k == 6) check("b2b_result_b", result31, 32'hBF00_0000);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
